// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with word-serial line refill
//
// Purpose: serves instruction fetches from stage F. Hits, bypassed addresses and idle
// cycles answer in the same cycle. A miss refills the whole line from backing memory,
// one word per req/ack handshake, then looks the address up again.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   IAddr, IREn         fetch byte address and fetch request from F
//   IRData, IReady      fetched word; IReady=0 stalls F
//   mem_req, mem_addr   backing word read request and word-aligned address
//   mem_rdata, mem_ack  backing read data, valid on the one-cycle ack pulse
//   hit_cnt, miss_cnt   lookup statistics, present only with ICACHE_STATS_EN defined
//
// Optional feature macro: ICACHE_STATS_EN (hit/miss counters and their ports).

module icache_dm #(
    parameter int          LINE_LOG2     = 2,
    parameter int          SETS_LOG2     = 6,
    parameter logic [31:0] IM_ADDR_START = 32'h0000_3000,
    parameter logic [31:0] IM_ADDR_END   = 32'h0000_7000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IAddr,
    input  logic        IREn,
    output logic [31:0] IRData,
    output logic        IReady,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int IDX_LO = LINE_LOG2 + 2;
    localparam int TAG_LO = IDX_LO + SETS_LOG2;
    localparam int TAG_W  = 32 - TAG_LO;
    localparam int WORDS  = 1 << LINE_LOG2;
    localparam int SETS   = 1 << SETS_LOG2;
    localparam logic [LINE_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [31:0]       data_mem [SETS*WORDS];
    logic [LINE_LOG2-1:0] cnt;

    // Lookup fields of the incoming fetch address.
    logic [SETS_LOG2-1:0]           req_index;
    logic [TAG_W-1:0]               req_tag;
    logic [SETS_LOG2+LINE_LOG2-1:0] req_word;

    // The refill position lives entirely in mem_addr: its line base was latched on the
    // miss and its offset bits track cnt, so no separate base register is kept.
    logic [SETS_LOG2-1:0]           fill_index;
    logic [TAG_W-1:0]               fill_tag;
    logic [SETS_LOG2+LINE_LOG2-1:0] fill_word;

    logic bypass;
    logic hit;
    logic lookup;
    logic start_fill;
    logic fill_ack;
    logic fill_done;

    assign req_index  = IAddr[TAG_LO-1:IDX_LO];
    assign req_tag    = IAddr[31:TAG_LO];
    assign req_word   = IAddr[TAG_LO-1:2];
    assign fill_index = mem_addr[TAG_LO-1:IDX_LO];
    assign fill_tag   = mem_addr[31:TAG_LO];
    assign fill_word  = mem_addr[TAG_LO-1:2];

    assign bypass = (IAddr < IM_ADDR_START) || (IAddr >= IM_ADDR_END) || (IAddr[1:0] != 2'b00);
    assign hit    = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign lookup = IREn && !bypass;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        IReady     = 1'b0;
        IRData     = 32'h0;
        start_fill = 1'b0;
        fill_ack   = 1'b0;
        fill_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (lookup && !hit) begin
                    start_fill = 1'b1;
                    state_next = S_FILL;
                end else begin
                    IReady = 1'b1;
                    if (lookup) begin
                        IRData = data_mem[req_word];
                    end
                end
            end
            S_FILL: begin
                fill_ack = mem_ack;
                if (mem_ack && (cnt == CNT_LAST)) begin
                    fill_done  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- refill control
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
            cnt      <= '0;
        end else if (start_fill) begin
            mem_req  <= 1'b1;
            mem_addr <= {IAddr[31:IDX_LO], {IDX_LO{1'b0}}};
            cnt      <= '0;
        end else if (fill_ack) begin
            if (cnt == CNT_LAST) begin
                mem_req           <= 1'b0;
                valid[fill_index] <= 1'b1;
            end else begin
                cnt      <= cnt + 1'b1;
                mem_addr <= mem_addr + 32'd4;
            end
        end
    end

    // Tag and data arrays carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (!reset && fill_ack) begin
            data_mem[fill_word] <= mem_rdata;
        end
        if (!reset && fill_done) begin
            tag_mem[fill_index] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // ---------------------------------------------------------------- statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= 32'h0;
            miss_cnt <= 32'h0;
        end else begin
            if ((state == S_IDLE) && lookup && hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_fill) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
